// File: rtl/uart_rx_byte.sv
// ============================================================================
// uart_rx_byte : 8N1 UART receiver that strobes each good byte onto uart_in/uart_rw
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clock,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] uart_in,
    output logic       uart_rw,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] STOP     = 3'd3;
    localparam logic [2:0] BRK_WAIT = 3'd4;

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);

    logic        rx_meta_q, rx_s_q;
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  uart_in_q, uart_in_d;
    logic        uart_rw_q, uart_rw_d;
    logic        frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        uart_in_d   = uart_in_q;
        uart_rw_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = 16'd0;
                end
            end
            START: begin
                // Mid start bit: a high line here means the falling edge was a glitch
                if (cnt_q == HALF_M1) begin
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = 16'd0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = 16'd0;
                    if (rx_s_q) begin
                        uart_in_d = shift_q;
                        uart_rw_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BRK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            BRK_WAIT: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            uart_in_q   <= 8'h00;
            uart_rw_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            uart_in_q   <= uart_in_d;
            uart_rw_q   <= uart_rw_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign uart_in   = uart_in_q;
    assign uart_rw   = uart_rw_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
// ============================================================================
// tb_uart_rx_byte : directed bench for uart_rx_byte at 16 clocks per bit
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_byte;

    logic       Clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] uart_in;
    logic       uart_rw;
    logic       frame_err;
    logic       rx_busy;

    int cyc    = 0;
    int rw_n   = 0;
    int fe_n   = 0;
    int busy_n = 0;
    int rise_n = 0;
    int both_n = 0;
    int rw_cyc [32];
    logic [7:0] rw_dat [32];
    int fe_cyc = 0;
    logic prev_rw = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int last_start = 0;
    int starts [5];
    int base_rw, base_fe, base_busy;

    uart_rx_byte #(.CLKS_PER_BIT(16)) dut (
        .Clock     (Clock),
        .rst_n     (rst_n),
        .rx        (rx),
        .uart_in   (uart_in),
        .uart_rw   (uart_rw),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Strobe recorder, sampled mid-cycle
    always @(negedge Clock) begin
        if (uart_rw) begin
            if (rw_n < 32) begin
                rw_cyc[rw_n] = cyc;
                rw_dat[rw_n] = uart_in;
            end
            rw_n = rw_n + 1;
        end
        if (uart_rw && !prev_rw) rise_n = rise_n + 1;
        if (frame_err) begin
            fe_n   = fe_n + 1;
            fe_cyc = cyc;
        end
        if (uart_rw && frame_err) both_n = both_n + 1;
        if (rx_busy) busy_n = busy_n + 1;
        prev_rw = uart_rw;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Must be called right at a rising edge; returns at a rising edge
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        #1 rx = 1'b0;
        last_start = cyc;
        repeat (16) @(posedge Clock);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (16) @(posedge Clock);
        end
        #1 rx = stop_val;
        repeat (16) @(posedge Clock);
    endtask

    initial begin
        // 1. reset with rx toggling
        repeat (10) begin
            @(posedge Clock);
            #1 rx = ~rx;
        end
        @(negedge Clock);
        check("rst_uart_in", uart_in, 8'h00);
        check("rst_uart_rw", uart_rw, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_rx_busy", rx_busy, 1'b0);
        @(posedge Clock);
        #1 rx = 1'b1;
        rst_n = 1'b1;
        repeat (100) @(posedge Clock);
        @(negedge Clock);
        check("idle_uart_in", uart_in, 8'h00);
        check("idle_rw_count", rw_n, 0);
        check("idle_fe_count", fe_n, 0);
        check("idle_rx_busy", rx_busy, 1'b0);

        // 2. single byte 0xA5
        base_rw = rw_n;
        base_fe = fe_n;
        @(posedge Clock);
        send_frame(8'hA5, 1'b1);
        @(negedge Clock);
        check("a5_rw_count", rw_n - base_rw, 1);
        check("a5_latency", rw_cyc[base_rw] - last_start, 155);
        check("a5_data", rw_dat[base_rw], 8'hA5);
        check("a5_fe_count", fe_n - base_fe, 0);
        repeat (50) @(negedge Clock);
        check("a5_held", uart_in, 8'hA5);
        check("a5_rw_after", rw_n - base_rw, 1);

        // 3. back-to-back burst
        base_rw = rw_n;
        @(posedge Clock);
        send_frame(8'h02, 1'b1); starts[0] = last_start;
        send_frame(8'h11, 1'b1); starts[1] = last_start;
        send_frame(8'h22, 1'b1); starts[2] = last_start;
        send_frame(8'h33, 1'b1); starts[3] = last_start;
        send_frame(8'h44, 1'b1); starts[4] = last_start;
        @(negedge Clock);
        check("burst_rw_count", rw_n - base_rw, 5);
        check("burst_latency0", rw_cyc[base_rw] - starts[0], 155);
        check("burst_d0", rw_dat[base_rw + 0], 8'h02);
        check("burst_d1", rw_dat[base_rw + 1], 8'h11);
        check("burst_d2", rw_dat[base_rw + 2], 8'h22);
        check("burst_d3", rw_dat[base_rw + 3], 8'h33);
        check("burst_d4", rw_dat[base_rw + 4], 8'h44);
        for (int k = 0; k < 4; k++) begin
            check("burst_spacing", rw_cyc[base_rw + k + 1] - rw_cyc[base_rw + k], 160);
        end
        check("burst_rises", rise_n, rw_n);

        // 4. start-bit glitch
        base_rw   = rw_n;
        base_fe   = fe_n;
        base_busy = busy_n;
        @(posedge Clock);
        #1 rx = 1'b0;
        repeat (4) @(posedge Clock);
        #1 rx = 1'b1;
        repeat (40) @(posedge Clock);
        @(negedge Clock);
        check("glitch_busy_cycles", busy_n - base_busy, 8);
        check("glitch_rw", rw_n - base_rw, 0);
        check("glitch_fe", fe_n - base_fe, 0);
        check("glitch_idle", rx_busy, 1'b0);

        // 5. framing error then break, then a good byte
        base_rw = rw_n;
        base_fe = fe_n;
        @(posedge Clock);
        send_frame(8'h3C, 1'b0);
        @(negedge Clock);
        check("ferr_fe_count", fe_n - base_fe, 1);
        check("ferr_latency", fe_cyc - last_start, 155);
        check("ferr_rw_count", rw_n - base_rw, 0);
        check("ferr_uart_in", uart_in, 8'h44);
        check("ferr_busy", rx_busy, 1'b1);
        repeat (40) @(negedge Clock);
        check("brk_fe_count", fe_n - base_fe, 1);
        check("brk_rw_count", rw_n - base_rw, 0);
        check("brk_busy", rx_busy, 1'b1);
        @(posedge Clock);
        #1 rx = 1'b1;
        repeat (20) @(posedge Clock);
        send_frame(8'h5A, 1'b1);
        @(negedge Clock);
        check("post_brk_rw", rw_n - base_rw, 1);
        check("post_brk_data", uart_in, 8'h5A);
        check("post_brk_fe", fe_n - base_fe, 1);
        check("no_overlap", both_n, 0);

        // 6. reset in the middle of data bit 4 of 0xFF
        base_rw = rw_n;
        base_fe = fe_n;
        @(posedge Clock);
        #1 rx = 1'b0;
        repeat (16) @(posedge Clock);
        #1 rx = 1'b1;
        repeat (72) @(posedge Clock);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_uart_in", uart_in, 8'h00);
        check("mid_rst_busy", rx_busy, 1'b0);
        check("mid_rst_rw", uart_rw, 1'b0);
        check("mid_rst_fe", frame_err, 1'b0);
        repeat (3) @(posedge Clock);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge Clock);
        check("mid_rst_no_rw", rw_n - base_rw, 0);
        check("mid_rst_no_fe", fe_n - base_fe, 0);
        send_frame(8'h81, 1'b1);
        @(negedge Clock);
        check("after_rst_rw", rw_n - base_rw, 1);
        check("after_rst_data", uart_in, 8'h81);
        check("final_rises", rise_n, rw_n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
